// File: rtl/can_rx_bit_sequencer_pkg.sv
// can_rx_pkg: shared state type, default sizing and bus level constants
// for the CAN receive bit sequencer.
package can_rx_pkg;
    typedef enum logic [1:0] {IDLE, RX, EOF_WAIT, ERR} rx_state_t;
    localparam int IDLE_BITS_DEF = 11;
    localparam int STUFF_LEN_DEF = 5;
    localparam int PER_W_DEF     = 23;
    localparam logic DOM = 1'b0;
    localparam logic REC = 1'b1;
endpackage

// File: rtl/can_rx_bit_sequencer_if.sv
// can_rx_bit_sequencer_if: received-byte valid/ready stream from the
// sequencer (master) to the channel unit (slave).
interface can_rx_bit_sequencer_if;
    logic [7:0] data;
    logic [3:0] bits;
    logic       last;
    logic       valid;
    logic       ready;
    modport master (output data, bits, last, valid, input ready);
    modport slave  (input data, bits, last, valid, output ready);
endinterface

// File: rtl/can_rx_bit_sequencer_voter.sv
// can_bit_voter: strobe index and 2-of-3 majority vote, resolving one bit
// on every third sample strobe (used when CAN_TRIPLE_SAMPLE_EN is defined).
module can_bit_voter
    import can_rx_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic sync_in,
    input  logic sample_stb,
    input  logic override,
    output logic bit_vld,
    output logic bit_val
);
    logic [1:0] idx, s;
    logic       sync_q, restart;
    // an edge the sync unit may resync on restarts the bit, so the vote restarts with it
    assign restart = sync_in != sync_q && !override;
    assign bit_vld = sample_stb && idx == 2'd2 && !restart;
    assign bit_val = (s[1] & s[0]) | (s[1] & sync_in) | (s[0] & sync_in);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx    <= '0;
            s      <= '0;
            sync_q <= REC;
        end else begin
            sync_q <= sync_in;
            if (restart) idx <= '0;
            else if (sample_stb) begin
                idx <= idx == 2'd2 ? 2'd0 : idx + 2'd1;
                s   <= {s[0], sync_in};
            end
        end
    end
endmodule

// File: rtl/can_rx_bit_sequencer.sv
// can_rx_bit_sequencer: CAN RX bit sequencer - bus idle/SOF tracking, destuffing,
// stuff-error detection and byte packing. CAN_TRIPLE_SAMPLE_EN enables 3-sample voting.
module can_rx_bit_sequencer
    import can_rx_pkg::*;
#(
    parameter int IDLE_BITS = IDLE_BITS_DEF,
    parameter int STUFF_LEN = STUFF_LEN_DEF,
    parameter int PER_W     = PER_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic [PER_W-1:0]       bit_period_in,
    output logic [PER_W-1:0]       bit_period,
    input  logic                   sync_in,
    input  logic                   sample_stb,
    output logic                   override,
    output logic                   multi_select,
    output logic                   stuff_err,
    output logic                   overflow,
    output logic                   bus_idle,
    can_rx_bit_sequencer_if.master rx
);
    localparam int CW = $clog2(IDLE_BITS + 1);
    localparam int RW = $clog2(STUFF_LEN + 2);

    rx_state_t     state;
    logic [CW-1:0] cnt;
    logic [RW-1:0] run_cnt;
    logic          run_val, bit_vld, bit_val;
    logic [7:0]    sh, emit_data;
    logic [3:0]    sh_n, tail, keep, emit_bits;
    logic          in_rx, same, at_lim, s_err, eof, data_b, full, emit, tag_last;

`ifdef CAN_TRIPLE_SAMPLE_EN
    can_bit_voter u_voter (
        .clk        (clk),
        .reset_n    (reset_n),
        .sync_in    (sync_in),
        .sample_stb (sample_stb),
        .override   (override),
        .bit_vld    (bit_vld),
        .bit_val    (bit_val)
    );
    assign multi_select = state != IDLE;
`else
    assign bit_vld      = sample_stb;
    assign bit_val      = sync_in;
    assign multi_select = 1'b0;
`endif

    assign in_rx  = enable && state == RX && bit_vld;
    assign same   = bit_val == run_val;
    assign at_lim = run_cnt == RW'(STUFF_LEN);
    assign s_err  = in_rx && at_lim && same && bit_val == DOM;
    assign eof    = in_rx && at_lim && same && bit_val == REC;
    assign data_b = in_rx && !at_lim;
    assign full   = data_b && sh_n == 4'd7;
    // trailing recessive bits of the partial byte belong to the end-of-frame run
    assign keep      = sh_n - tail;
    assign emit      = full || (eof && keep != 4'd0);
    assign emit_data = full ? {sh[6:0], bit_val} : (sh << (4'd8 - sh_n)) & ~(8'hff >> keep);
    assign emit_bits = full ? 4'd8 : keep;
    assign tag_last  = eof && keep == 4'd0 && rx.valid && !rx.ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            bit_period <= '0;
            override   <= 1'b1;
            stuff_err  <= 1'b0;
            bus_idle   <= 1'b0;
            cnt        <= '0;
            run_cnt    <= '0;
            run_val    <= REC;
            sh         <= '0;
            sh_n       <= '0;
            tail       <= '0;
        end else begin
            stuff_err <= s_err;
            if (state == IDLE) bit_period <= bit_period_in;
            if (!enable) begin
                state    <= IDLE;
                override <= 1'b1;
                bus_idle <= 1'b0;
                cnt      <= '0;
            end else case (state)
                IDLE: begin
                    override <= bit_vld && bit_val == DOM;
                    if (bit_vld && bit_val == DOM) begin
                        state    <= RX;
                        run_val  <= DOM;
                        run_cnt  <= RW'(1);
                        sh_n     <= '0;
                        tail     <= '0;
                        bus_idle <= 1'b0;
                        cnt      <= '0;
                    end else if (bit_vld && !bus_idle) begin
                        cnt      <= cnt + 1'b1;
                        bus_idle <= cnt == CW'(IDLE_BITS - 1);
                    end
                end
                RX: if (bit_vld) begin
                    override <= bit_val == DOM;
                    run_val  <= bit_val;
                    run_cnt  <= same ? run_cnt + 1'b1 : RW'(1);
                    if (s_err) begin
                        state <= ERR;
                        cnt   <= '0;
                    end else if (eof) begin
                        state <= EOF_WAIT;
                        cnt   <= CW'(STUFF_LEN + 1);
                    end else if (data_b) begin
                        sh   <= {sh[6:0], bit_val};
                        sh_n <= full ? 4'd0 : sh_n + 4'd1;
                        tail <= (full || bit_val == DOM) ? 4'd0 : tail + 4'd1;
                    end
                end
                // EOF_WAIT and ERR both wait out IDLE_BITS recessive bits; dominant restarts the count
                default: if (bit_vld) begin
                    override <= state == ERR || bit_val == DOM;
                    if (bit_val == DOM) cnt <= '0;
                    else if (cnt == CW'(IDLE_BITS - 1)) begin
                        state    <= IDLE;
                        bus_idle <= 1'b1;
                        override <= 1'b0;
                    end else cnt <= cnt + 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx.data  <= '0;
            rx.bits  <= '0;
            rx.last  <= 1'b0;
            rx.valid <= 1'b0;
            overflow <= 1'b0;
        end else begin
            overflow <= emit && rx.valid && !rx.ready;
            if (emit && !(rx.valid && !rx.ready)) begin
                rx.data  <= emit_data;
                rx.bits  <= emit_bits;
                rx.last  <= eof;
                rx.valid <= 1'b1;
            end else if (tag_last) rx.last <= 1'b1;
            else if (rx.ready) rx.valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_can_rx_bit_sequencer.sv
// tb_can_rx_bit_sequencer: directed self-checking bench for can_rx_bit_sequencer;
// adapts bit timing and the vote step when CAN_TRIPLE_SAMPLE_EN is defined.
module tb_can_rx_bit_sequencer;
    localparam int PER_W = 23;
    logic clk = 1'b0, reset_n = 1'b0, enable = 1'b1, sync_in = 1'b1, sample_stb = 1'b0;
    logic [PER_W-1:0] bit_period_in = 23'd500;
    logic [PER_W-1:0] bit_period;
    logic override, multi_select, stuff_err, overflow, bus_idle;
    int tests = 0, fails = 0;

    can_rx_bit_sequencer_if rx_if();

    can_rx_bit_sequencer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .bit_period_in (bit_period_in),
        .bit_period    (bit_period),
        .sync_in       (sync_in),
        .sample_stb    (sample_stb),
        .override      (override),
        .multi_select  (multi_select),
        .stuff_err     (stuff_err),
        .overflow      (overflow),
        .bus_idle      (bus_idle),
        .rx            (rx_if)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // level is set one cycle ahead of the strobe, as the sync unit would present it
    task automatic stb(input logic v);
        @(negedge clk) sync_in = v;
        @(negedge clk) sample_stb = 1'b1;
        @(negedge clk) sample_stb = 1'b0;
    endtask

    task automatic send(input logic v);
`ifdef CAN_TRIPLE_SAMPLE_EN
        stb(v);
        stb(v);
`endif
        stb(v);
    endtask

    task automatic send_n(input logic v, input int n);
        for (int i = 0; i < n; i++) send(v);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send(b[i]);
    endtask

    initial begin
        rx_if.ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_bit_period", bit_period, 0);
        check("rst_override", override, 1);
        check("rst_multi", multi_select, 0);
        check("rst_data", rx_if.data, 0);
        check("rst_bits", rx_if.bits, 0);
        check("rst_last", rx_if.last, 0);
        check("rst_valid", rx_if.valid, 0);
        check("rst_stuff_err", stuff_err, 0);
        check("rst_overflow", overflow, 0);
        check("rst_bus_idle", bus_idle, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_bit_period", bit_period, 500);
        check("idle_override", override, 0);

        // bus idle after 11 recessive bits
        send_n(1'b1, 10);
        check("idle_10", bus_idle, 0);
        send(1'b1);
        check("idle_11", bus_idle, 1);

        // 0xA5 held unaccepted, end of frame tags it as last
        rx_if.ready = 1'b0;
        send(1'b0);
        check("sof_bus_idle", bus_idle, 0);
        check("sof_override", override, 1);
        send_byte(8'hA5);
        check("a5_valid", rx_if.valid, 1);
        check("a5_data", rx_if.data, 8'hA5);
        check("a5_bits", rx_if.bits, 8);
        check("a5_last0", rx_if.last, 0);
        send_n(1'b1, 5);
        check("a5_last1", rx_if.last, 1);
        check("a5_hold", rx_if.data, 8'hA5);
        check("eof_override", override, 0);
        send_n(1'b1, 4);
        check("eofw_idle0", bus_idle, 0);
        send(1'b1);
        check("eofw_idle1", bus_idle, 1);
        rx_if.ready = 1'b1;
        @(negedge clk);
        check("a5_taken", rx_if.valid, 0);

        // stuff bit dropped, then a 2-bit final partial byte
        send(1'b0);
        send_n(1'b0, 4);
        send(1'b1);
        send(1'b0); send(1'b1); send(1'b0); send(1'b1);
        check("stuff_valid", rx_if.valid, 1);
        check("stuff_data", rx_if.data, 8'h05);
        check("stuff_bits", rx_if.bits, 8);
        send(1'b1); send(1'b0);
        send_n(1'b1, 5);
        check("part_none", rx_if.valid, 0);
        send(1'b1);
        check("part_valid", rx_if.valid, 1);
        check("part_data", rx_if.data, 8'h80);
        check("part_bits", rx_if.bits, 2);
        check("part_last", rx_if.last, 1);
        send_n(1'b1, 5);
        check("part_idle", bus_idle, 1);

        // six dominant -> stuff error, recovery needs 11 recessive
        send(1'b0);
        send_n(1'b0, 4);
        check("serr_pre", stuff_err, 0);
        send(1'b0);
        check("serr_pulse", stuff_err, 1);
        check("serr_override", override, 1);
        check("serr_no_byte", rx_if.valid, 0);
        @(negedge clk);
        check("serr_pulse_end", stuff_err, 0);
        send_n(1'b1, 10);
        check("err_idle_10", bus_idle, 0);
        send(1'b0);
        send_n(1'b1, 10);
        check("err_restart_10", bus_idle, 0);
        send(1'b1);
        check("err_idle_11", bus_idle, 1);
        check("err_override", override, 0);

        // back-pressure: second byte overflows, first stays stable
        rx_if.ready = 1'b0;
        send(1'b0);
        send_byte(8'h3C);
        check("ovf_first", rx_if.data, 8'h3C);
        send_byte(8'hC3);
        check("ovf_pulse", overflow, 1);
        check("ovf_valid", rx_if.valid, 1);
        check("ovf_data", rx_if.data, 8'h3C);
        check("ovf_bits", rx_if.bits, 8);
        @(negedge clk);
        check("ovf_pulse_end", overflow, 0);
        send_n(1'b1, 4);
        check("ovf_last", rx_if.last, 1);
        rx_if.ready = 1'b1;
        @(negedge clk);
        check("ovf_taken", rx_if.valid, 0);
        send_n(1'b1, 5);
        check("ovf_idle", bus_idle, 1);

        // enable dropped mid-frame; bit period frozen outside IDLE
        send(1'b0);
        bit_period_in = 23'd777;
        send(1'b1); send(1'b1);
        check("per_frozen", bit_period, 500);
        enable = 1'b0;
        @(negedge clk);
        check("dis_override", override, 1);
        check("dis_bus_idle", bus_idle, 0);
        @(negedge clk);
        check("dis_reload", bit_period, 777);
        enable = 1'b1;
        @(negedge clk);
        check("en_override", override, 0);
        send_n(1'b1, 11);
        check("en_idle", bus_idle, 1);
        check("en_no_byte", rx_if.valid, 0);

        // voted/last bit, then asynchronous reset mid-frame
        rx_if.ready = 1'b0;
        send(1'b0);
`ifdef CAN_TRIPLE_SAMPLE_EN
        check("multi_frame", multi_select, 1);
`else
        check("multi_frame", multi_select, 0);
`endif
        send(1'b1); send(1'b0); send(1'b1); send(1'b0); send(1'b0); send(1'b1); send(1'b0);
        check("vote_override", override, 1);
`ifdef CAN_TRIPLE_SAMPLE_EN
        stb(1'b0); stb(1'b1); stb(1'b0);
`else
        send(1'b0);
`endif
        check("vote_valid", rx_if.valid, 1);
        check("vote_data", rx_if.data, 8'hA4);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst_valid", rx_if.valid, 0);
        check("arst_data", rx_if.data, 0);
        check("arst_override", override, 1);
        check("arst_bit_period", bit_period, 0);
        check("arst_multi", multi_select, 0);
        @(negedge clk) reset_n = 1'b1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
